poci_serializer: RTL and testbench

SPI peripheral-out (POCI) transmitter; it is the readback counterpart of the PICO receive path. It decodes the first byte of each transaction as a read/write command plus a start address, then streams register contents out MSB-first on poci. It drives the readback mux address and auto-increments through a register burst. A transaction ends when rstn is asserted by the sclk-stop detector.

---
 rtl/poci_serializer.sv | 94 +++++++++
 tb/tb_poci_serializer.sv | 115 +++++++++++
 2 files changed

// File: rtl/poci_serializer.sv
// SPI POCI transmitter: decodes a read/write command byte, then streams
// readback-mux bytes MSB-first with an auto-incrementing, wrapping address.
`timescale 1ns/1ps
module poci_serializer #(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 8
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              pico,
  input  logic [DATA_W-1:0] rd_data,
  output logic              poci,
  output logic [6:0]        rd_addr,
  output logic              tx_active,
  output logic              byte_done
);

  typedef enum logic [1:0] {ST_ADDR, ST_READ, ST_WRITE} state_e;

  localparam logic [6:0] LAST_ADDR = 7'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] cmd_q, cmd_d, cmd_next;
  logic [6:0]        rd_addr_q, rd_addr_d;
  logic              tx_active_q, tx_active_d;
  logic              byte_done_q, byte_done_d;
  logic [DATA_W-1:0] tx_q, tx_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    cmd_d       = cmd_q;
    cmd_next    = {cmd_q[DATA_W-2:0], pico};
    rd_addr_d   = rd_addr_q;
    tx_active_d = tx_active_q;
    byte_done_d = 1'b0;
    case (state_q)
      ST_ADDR: begin
        cmd_d = cmd_next;
        if (bit_cnt_q == 3'd7) begin
          state_d     = cmd_next[DATA_W-1] ? ST_READ : ST_WRITE;
          tx_active_d = cmd_next[DATA_W-1];
          // Out-of-range start addresses fold back into the register file.
          rd_addr_d   = 7'({25'd0, cmd_next[6:0]} % NUM_REGS);
        end
      end
      ST_READ: begin
        if (bit_cnt_q == 3'd7) begin
          byte_done_d = 1'b1;
          rd_addr_d   = (rd_addr_q == LAST_ADDR) ? 7'd0 : rd_addr_q + 7'd1;
        end
      end
      default: ;
    endcase
  end

  // Shift register runs on the falling edge so each bit is stable for the
  // host's rising-edge sample; bit_cnt==0 marks the start of a new byte.
  always_comb begin
    tx_d = tx_q;
    if (state_q == ST_READ)
      tx_d = (bit_cnt_q == 3'd0) ? rd_data : {tx_q[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_ADDR;
      bit_cnt_q   <= 3'd0;
      cmd_q       <= '0;
      rd_addr_q   <= 7'd0;
      tx_active_q <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      rd_addr_q   <= rd_addr_d;
      tx_active_q <= tx_active_d;
      byte_done_q <= byte_done_d;
    end
  end

  always_ff @(negedge sclk or negedge rstn) begin
    if (!rstn) tx_q <= '0;
    else       tx_q <= tx_d;
  end

  assign poci      = (state_q == ST_READ) ? tx_q[DATA_W-1] : 1'b0;
  assign rd_addr   = rd_addr_q;
  assign tx_active = tx_active_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_poci_serializer.sv
// Scoreboard bench for poci_serializer: per-posedge expectations derived from
// transaction position, checked by an independent monitor.
`timescale 1ns/1ps
module tb_poci_serializer;
  localparam int NUM_REGS = 128;

  logic       sclk = 1'b0;
  logic       rstn = 1'b0;
  logic       pico = 1'b0;
  logic [7:0] rd_data;
  logic       poci;
  logic [6:0] rd_addr;
  logic       tx_active;
  logic       byte_done;

  logic [7:0] mem [NUM_REGS];

  typedef struct packed {
    logic       poci;
    logic       tx;
    logic [6:0] addr;
    logic       bd;
  } exp_t;

  exp_t expq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  poci_serializer #(.NUM_REGS(NUM_REGS), .DATA_W(8)) dut (
    .sclk(sclk), .rstn(rstn), .pico(pico), .rd_data(rd_data),
    .poci(poci), .rd_addr(rd_addr), .tx_active(tx_active), .byte_done(byte_done)
  );

  always #5 sclk = ~sclk;

  assign rd_data = mem[rd_addr];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Monitor: every posedge that has a pending expectation is checked.
  always begin
    exp_t e;
    @(posedge sclk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("poci",      int'(poci),      int'(e.poci));
      chk("tx_active", int'(tx_active), int'(e.tx));
      chk("rd_addr",   int'(rd_addr),   int'(e.addr));
      chk("byte_done", int'(byte_done), int'(e.bd));
    end
  end

  // Drive len posedges of one transaction, then end it with reset.
  // Expected outputs after posedge k come from the position in the stream.
  task automatic run_txn(input logic [7:0] cmd, input int len);
    int   a;
    bit   rd;
    exp_t e;
    a  = int'(cmd[6:0]) % NUM_REGS;
    rd = cmd[7];
    for (int k = 1; k <= len; k++) begin
      @(negedge sclk);
      rstn = 1'b1;
      pico = (k <= 8) ? cmd[8-k] : 1'($urandom_range(0, 1));
      e.poci = (rd && k >= 9) ? mem[(a + (k-9)/8) % NUM_REGS][7 - ((k-9) % 8)] : 1'b0;
      e.tx   = rd && (k >= 8);
      e.addr = (k < 8) ? 7'd0 : (rd ? 7'((a + (k-8)/8) % NUM_REGS) : 7'(a));
      e.bd   = rd && (k >= 16) && ((k-8) % 8 == 0);
      expq.push_back(e);
    end
    @(negedge sclk);
    #1 rstn = 1'b0;
    #1;
    chk("rst_poci",      int'(poci),      0);
    chk("rst_rd_addr",   int'(rd_addr),   0);
    chk("rst_tx_active", int'(tx_active), 0);
    chk("rst_byte_done", int'(byte_done), 0);
    chk("sb_drained",    expq.size(),     0);
    expq.delete();
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 8'($urandom);
    mem[5] = 8'hA5; mem[6] = 8'h3C; mem[7] = 8'hFF;
    mem[127] = 8'h11; mem[0] = 8'h22;
    #12;
    chk("init_poci",    int'(poci),    0);
    chk("init_rd_addr", int'(rd_addr), 0);
    run_txn(8'h85, 16);   // single read byte
    run_txn(8'h85, 32);   // burst A5,3C,FF
    run_txn(8'h05, 24);   // write command
    run_txn(8'hFF, 24);   // wrap 127 -> 0
    run_txn(8'h85, 11);   // abort after 3 data bits
    run_txn(8'h81, 16);   // clean read after abort
    run_txn(8'h9A, 5);    // short command phase
    for (int t = 0; t < 30; t++) begin
      if (t % 10 == 0)
        for (int i = 0; i < NUM_REGS; i++) mem[i] = 8'($urandom);
      run_txn(8'($urandom), int'($urandom_range(1, 44)));
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
endmodule
